// File: rtl/uart_tx_arbiter_if.sv
// Bundle between the SoC byte-stream requesters, the arbiter and the shared UART_TX.
// Signal names are taken from the arbiter's point of view (i_ = into arbiter, o_ = out of it).
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   i_Req_Valid;
  logic [8*NUM_REQ-1:0] i_Req_Byte;
  logic [NUM_REQ-1:0]   i_Req_Last;
  logic [NUM_REQ-1:0]   o_Req_Ready;
  logic [NUM_REQ-1:0]   o_Grant;
  logic                 o_Tx_DV;
  logic [7:0]           o_Tx_Byte;
  logic                 i_Tx_Active;
  logic                 i_Tx_Done;
  logic                 o_Timeout;

  modport master (
    output i_Req_Valid, i_Req_Byte, i_Req_Last, i_Tx_Active, i_Tx_Done,
    input  o_Req_Ready, o_Grant, o_Tx_DV, o_Tx_Byte, o_Timeout
  );

  modport slave (
    input  i_Req_Valid, i_Req_Byte, i_Req_Last, i_Tx_Active, i_Tx_Done,
    output o_Req_Ready, o_Grant, o_Tx_DV, o_Tx_Byte, o_Timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART_TX among NUM_REQ requesters.
// Optional macro UART_ARB_TAG_EN: each new grant first sends tag byte 8'hF0 | owner index.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int HOLD_TIMEOUT = 1024
) (
  input logic              i_Clock,
  input logic              i_Reset,
  uart_tx_arbiter_if.slave arb
);
  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(HOLD_TIMEOUT) + 1;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] ISSUE     = 2'd1;
  localparam logic [1:0] WAIT_DONE = 2'd2;
`ifdef UART_ARB_TAG_EN
  localparam logic [1:0] TAG       = 2'd3;
`endif

  logic [1:0]         r_State;
  logic [IDX_W-1:0]   r_Ptr;
  logic [IDX_W-1:0]   r_Grant_Idx;
  logic [CNT_W-1:0]   r_Idle_Cnt;
  logic               r_Last;
  logic [NUM_REQ-1:0] r_Grant;
  logic [NUM_REQ-1:0] r_Req_Ready;
  logic               r_Tx_DV;
  logic [7:0]         r_Tx_Byte;
  logic               r_Timeout;

  logic               w_Found;
  logic [IDX_W-1:0]   w_Pick;
  logic               w_Own_Valid;
  logic               w_Own_Last;
  logic [7:0]         w_Own_Byte;

  function automatic logic [IDX_W-1:0] f_Wrap(input int v);
    return IDX_W'(v % NUM_REQ);
  endfunction

  function automatic logic [IDX_W-1:0] f_Next(input logic [IDX_W-1:0] v);
    if (int'(v) == NUM_REQ - 1) return '0;
    return v + 1'b1;
  endfunction

  // First valid requester at or after the pointer, wrapping modulo NUM_REQ.
  always_comb begin
    w_Found = 1'b0;
    w_Pick  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!w_Found && arb.i_Req_Valid[f_Wrap(int'(r_Ptr) + i)]) begin
        w_Found = 1'b1;
        w_Pick  = f_Wrap(int'(r_Ptr) + i);
      end
    end
  end

  assign w_Own_Valid = arb.i_Req_Valid[r_Grant_Idx];
  assign w_Own_Last  = arb.i_Req_Last[r_Grant_Idx];
  assign w_Own_Byte  = arb.i_Req_Byte[{r_Grant_Idx, 3'b000} +: 8];

  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      r_State     <= IDLE;
      r_Ptr       <= '0;
      r_Grant_Idx <= '0;
      r_Idle_Cnt  <= '0;
      r_Last      <= 1'b0;
      r_Grant     <= '0;
      r_Req_Ready <= '0;
      r_Tx_DV     <= 1'b0;
      r_Tx_Byte   <= 8'h00;
      r_Timeout   <= 1'b0;
    end else begin
      r_Tx_DV     <= 1'b0;
      r_Req_Ready <= '0;
      r_Timeout   <= 1'b0;
      case (r_State)
        IDLE: begin
          if (w_Found) begin
            r_Grant     <= NUM_REQ'(1) << w_Pick;
            r_Grant_Idx <= w_Pick;
            r_Idle_Cnt  <= '0;
`ifdef UART_ARB_TAG_EN
            r_State     <= TAG;
`else
            r_State     <= ISSUE;
`endif
          end
        end
`ifdef UART_ARB_TAG_EN
        TAG: begin
          if (!arb.i_Tx_Active) begin
            r_Tx_DV   <= 1'b1;
            r_Tx_Byte <= 8'hF0 | 8'(r_Grant_Idx);
            r_Last    <= 1'b0;
            r_State   <= WAIT_DONE;
          end
        end
`endif
        // A busy UART stalls the owner without counting toward the hold timeout.
        ISSUE: begin
          if (!arb.i_Tx_Active) begin
            if (w_Own_Valid) begin
              r_Tx_DV     <= 1'b1;
              r_Tx_Byte   <= w_Own_Byte;
              r_Req_Ready <= NUM_REQ'(1) << r_Grant_Idx;
              r_Last      <= w_Own_Last;
              r_Idle_Cnt  <= '0;
              r_State     <= WAIT_DONE;
            end else if (r_Idle_Cnt == CNT_W'(HOLD_TIMEOUT - 1)) begin
              r_Timeout  <= 1'b1;
              r_Grant    <= '0;
              r_Ptr      <= f_Next(r_Grant_Idx);
              r_Idle_Cnt <= '0;
              r_State    <= IDLE;
            end else begin
              r_Idle_Cnt <= r_Idle_Cnt + 1'b1;
            end
          end
        end
        WAIT_DONE: begin
          if (arb.i_Tx_Done) begin
            if (r_Last) begin
              r_Grant <= '0;
              r_Ptr   <= f_Next(r_Grant_Idx);
              r_State <= IDLE;
            end else begin
              r_State <= ISSUE;
            end
          end
        end
        default: r_State <= IDLE;
      endcase
    end
  end

  assign arb.o_Req_Ready = r_Req_Ready;
  assign arb.o_Grant     = r_Grant;
  assign arb.o_Tx_DV     = r_Tx_DV;
  assign arb.o_Tx_Byte   = r_Tx_Byte;
  assign arb.o_Timeout   = r_Timeout;
endmodule
